vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 VGA raster timing from the 50 MHz board clock: pixel strobe, pixel coordinates, h_sync/v_sync and blanking.
- Sits inside top, directly upstream of the board pins. It drives h_sync, v_sync, RED, GREEN and BLUE, and feeds pix_x/pix_y to the pixel/colour generator.
- The colour generator returns 12-bit colour one pixel later. This block aligns that colour with delayed syncs and forces black during blanking.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIX_DIV, 2, Clock cycles per pixel (50 MHz / 2 = 25 MHz); legal values >= 1
- SYNC_POL, 0, active level of h_sync/v_sync (0 = active-low)

Ports:
- Clock  in  1  50 MHz system clock (CLK_50 in top)
- Reset  in  1  asynchronous, active-low reset; 0 = reset; driven from BUTTON[0] in top
- RED_in  in  4  colour for the pix_x/pix_y presented one pixel earlier
- GREEN_in  in  4  as RED_in
- BLUE_in  in  4  as RED_in
- pix_en  out  1  one-Clock pixel strobe, high once every PIX_DIV cycles
- pix_x  out  10  current horizontal count, 0..H_TOTAL-1
- pix_y  out  10  current vertical count, 0..V_TOTAL-1
- video_on  out  1  stage-0 active-area flag: pix_x<H_ACTIVE and pix_y<V_ACTIVE
- frame_start  out  1  high for the pix_en cycle where pix_x=0 and pix_y=0
- RED  out  4  registered output colour
- GREEN  out  4  registered output colour
- BLUE  out  4  registered output colour
- h_sync  out  1  horizontal sync, aligned with the RGB outputs
- v_sync  out  1  vertical sync, aligned with the RGB outputs

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Reset value of every output, held while Reset=0:
  - pix_en=0, pix_x=0, pix_y=0, video_on=0, frame_start=0
  - RGB=0
  - h_sync=v_sync=~SYNC_POL (inactive)
- Pixel divider:
  - div_cnt counts 0..PIX_DIV-1 and wraps.
  - pix_en is registered and is high in the cycle after div_cnt=PIX_DIV-1.
  - The first pix_en occurs PIX_DIV cycles after Reset deasserts. With PIX_DIV=1, pix_en is constantly high after the first cycle.
- Stage 0 counters, advanced only on pix_en:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and increments v_cnt.
  - v_cnt wraps to 0 after V_TOTAL-1 at the same h wrap.
  - pix_x=h_cnt and pix_y=v_cnt; they change only in pix_en cycles.
- Sync windows at stage 0, both inclusive:
  - h_sync is active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
  - v_sync is active for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491], over whole lines.
- Stage 1 alignment:
  - On pix_en, register video_on and the stage-0 sync levels into stage-1 flops.
  - On the same pix_en, RGB <= video_on_d1 ? {RED_in,GREEN_in,BLUE_in} : 0.
  - Net result: pin h_sync/v_sync/RGB lag pix_x/pix_y by exactly 1 pixel (PIX_DIV Clock cycles).
  - The colour generator must present the colour for (x,y) before the next pix_en.
- Blanking: RGB is forced to 0 whenever the aligned video_on is 0, regardless of the *_in values.
- frame_start: high for the single pix_en cycle in which counters are (0,0); 0 otherwise. It does not fire on the first strobe after reset.
- Reset mid-frame: all state clears asynchronously. Timing restarts at (0,0) with no partial sync pulse, and the first full line follows.
- Counter widths: 10 bits suffice for both counters. Parameters giving a total > 1023 are illegal.

Optional Feature:
- Macro: VGA_COLOR_BARS_EN
- Defined:
  - RED_in/GREEN_in/BLUE_in are ignored.
  - Inside the active area, the output colour is 8 vertical bars, each H_ACTIVE/8 = 80 px wide.
  - Bar index b = pix_x[9:0]/80; colour = {R=b[2]?F:0, G=b[1]?F:0, B=b[0]?F:0}.
  - Same 1-pixel alignment and blanking as normal mode.
- Undefined: normal pass-through behaviour as above; no bar logic is synthesised.

Test Plan:
- Reset held 40 ns, then released -> all outputs at reset values during reset; first pix_en 2 Clock cycles after release; pix_x increments every 2 cycles.
- Free run one line -> pix_x wraps 799->0 every 1600 Clock cycles. h_sync goes 0 for exactly 192 cycles, starting 1314 cycles after the pix_x=0 strobe (656 px plus 1 px alignment).
- Free run past 525 lines (840000 cycles, so extend the bench $finish) -> v_sync low for exactly 2 lines (3200 cycles) at pix_y 490..491 plus alignment; frame_start pulses once per 840000 cycles.
- Drive RED_in=GREEN_in=BLUE_in=4'hA constantly -> RGB=12'hAAA during active pixels and 12'h000 for pix_x>=640 or pix_y>=480, with the 1-pixel lag verified at the x=639->640 edge.
- Assert Reset for 3 cycles at pix_x=700, pix_y=200 -> outputs snap to reset values asynchronously; on release, counters restart at (0,0) and h_sync does not go active until pix_x=656.
- Compile with VGA_COLOR_BARS_EN and drive *_in=0 -> on line 0, RGB=000 for x 0..79, 00F for 80..159 … FFF for 560..639 (1-pixel lag); blanking remains 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA raster timing with 1-pixel colour/sync alignment
// Define VGA_COLOR_BARS_EN to replace the colour inputs with an 8-bar test pattern.
`timescale 1ns/1ps
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int PIX_DIV  = 2,
   parameter int SYNC_POL = 0
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [3:0] RED_in,
   input  logic [3:0] GREEN_in,
   input  logic [3:0] BLUE_in,
   output logic       pix_en,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic       video_on,
   output logic       frame_start,
   output logic [3:0] RED,
   output logic [3:0] GREEN,
   output logic [3:0] BLUE,
   output logic       h_sync,
   output logic       v_sync
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
   localparam logic SYNC_ON  = 1'(SYNC_POL);
   localparam logic SYNC_OFF = ~SYNC_ON;

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             pix_en_q, pix_en_d;
   logic [9:0]       h_cnt_q, h_cnt_d;
   logic [9:0]       v_cnt_q, v_cnt_d;
   logic             video_on_q, video_on_d;
   logic             frame_start_q, frame_start_d;
   logic             hs0_q, hs0_d;
   logic             vs0_q, vs0_d;
   logic             h_sync_q, h_sync_d;
   logic             v_sync_q, v_sync_d;
   logic [11:0]      rgb_q, rgb_d;

   logic             tick;
   logic [9:0]       h_next;
   logic [9:0]       v_next;
   logic [11:0]      colour;

`ifdef VGA_COLOR_BARS_EN
   localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
   logic [9:0] bar_idx;
   logic       unused_in;
   assign bar_idx   = h_cnt_q / BAR_W;
   assign colour    = {{4{bar_idx[2]}}, {4{bar_idx[1]}}, {4{bar_idx[0]}}};
   assign unused_in = ^{RED_in, GREEN_in, BLUE_in, bar_idx[9:3]};
`else
   assign colour = {RED_in, GREEN_in, BLUE_in};
`endif

   always_comb begin
      tick          = (div_cnt_q == DIV_LAST);
      div_cnt_d     = tick ? '0 : div_cnt_q + DIV_W'(1);
      h_next        = (h_cnt_q == H_LAST) ? 10'd0 : h_cnt_q + 10'd1;
      v_next        = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         v_next = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
      end

      pix_en_d      = tick;
      frame_start_d = 1'b0;
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      video_on_d    = video_on_q;
      hs0_d         = hs0_q;
      vs0_d         = vs0_q;
      h_sync_d      = h_sync_q;
      v_sync_d      = v_sync_q;
      rgb_d         = rgb_q;

      // Stage 0 moves to the next pixel while stage 1 takes the one just finished,
      // so pins always show the pixel that pix_x/pix_y showed one strobe earlier.
      if (tick) begin
         h_cnt_d       = h_next;
         v_cnt_d       = v_next;
         video_on_d    = (h_next < H_ACT) && (v_next < V_ACT);
         frame_start_d = (h_next == 10'd0) && (v_next == 10'd0);
         hs0_d         = (h_next >= HS_FIRST && h_next <= HS_LAST) ? SYNC_ON : SYNC_OFF;
         vs0_d         = (v_next >= VS_FIRST && v_next <= VS_LAST) ? SYNC_ON : SYNC_OFF;
         h_sync_d      = hs0_q;
         v_sync_d      = vs0_q;
         rgb_d         = video_on_q ? colour : 12'h000;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         div_cnt_q     <= '0;
         pix_en_q      <= 1'b0;
         h_cnt_q       <= 10'd0;
         v_cnt_q       <= 10'd0;
         video_on_q    <= 1'b0;
         frame_start_q <= 1'b0;
         hs0_q         <= SYNC_OFF;
         vs0_q         <= SYNC_OFF;
         h_sync_q      <= SYNC_OFF;
         v_sync_q      <= SYNC_OFF;
         rgb_q         <= 12'h000;
      end else begin
         div_cnt_q     <= div_cnt_d;
         pix_en_q      <= pix_en_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         video_on_q    <= video_on_d;
         frame_start_q <= frame_start_d;
         hs0_q         <= hs0_d;
         vs0_q         <= vs0_d;
         h_sync_q      <= h_sync_d;
         v_sync_q      <= v_sync_d;
         rgb_q         <= rgb_d;
      end
   end

   assign pix_en      = pix_en_q;
   assign pix_x       = h_cnt_q;
   assign pix_y       = v_cnt_q;
   assign video_on    = video_on_q;
   assign frame_start = frame_start_q;
   assign h_sync      = h_sync_q;
   assign v_sync      = v_sync_q;
   assign RED         = rgb_q[11:8];
   assign GREEN       = rgb_q[7:4];
   assign BLUE        = rgb_q[3:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized check of vga_timing_gen against a pixel-index reference model
// Instance a uses the default 640x480 timing, instance b a tiny raster so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_timing_gen;
   localparam int MASK = 16383;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] r_in, g_in, b_in;

   logic       a_pix_en, a_video_on, a_frame_start, a_hs, a_vs;
   logic [9:0] a_pix_x, a_pix_y;
   logic [3:0] a_red, a_green, a_blue;
   logic       b_pix_en, b_video_on, b_frame_start, b_hs, b_vs;
   logic [9:0] b_pix_x, b_pix_y;
   logic [3:0] b_red, b_green, b_blue;

   int         n_vec = 0;
   int         n_err = 0;
   int         cyc;
   logic [11:0] hist [0:MASK];

   always #10 clk = ~clk;

   vga_timing_gen dut_a (
      .Clock(clk), .Reset(rst_n), .RED_in(r_in), .GREEN_in(g_in), .BLUE_in(b_in),
      .pix_en(a_pix_en), .pix_x(a_pix_x), .pix_y(a_pix_y), .video_on(a_video_on),
      .frame_start(a_frame_start), .RED(a_red), .GREEN(a_green), .BLUE(a_blue),
      .h_sync(a_hs), .v_sync(a_vs)
   );

   vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .PIX_DIV(3), .SYNC_POL(1)
   ) dut_b (
      .Clock(clk), .Reset(rst_n), .RED_in(r_in), .GREEN_in(g_in), .BLUE_in(b_in),
      .pix_en(b_pix_en), .pix_x(b_pix_x), .pix_y(b_pix_y), .video_on(b_video_on),
      .frame_start(b_frame_start), .RED(b_red), .GREEN(b_green), .BLUE(b_blue),
      .h_sync(b_hs), .v_sync(b_vs)
   );

   wire [36:0] a_obs = {a_pix_en, a_pix_x, a_pix_y, a_video_on, a_frame_start, a_hs, a_vs, a_red, a_green, a_blue};
   wire [36:0] b_obs = {b_pix_en, b_pix_x, b_pix_y, b_video_on, b_frame_start, b_hs, b_vs, b_red, b_green, b_blue};

   // cyc = clock edges since reset release; hist[e] = colour inputs seen at edge e
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc <= 0;
      end else begin
         hist[(cyc + 1) & MASK] <= {r_in, g_in, b_in};
         cyc <= cyc + 1;
      end
   end

   // Expected outputs c edges after release: strobe k shows pixel k of the raster,
   // pins show pixel k-1 with the colour present at strobe edge k.
   function automatic logic [36:0] model(input int c, input int ha, input int hf, input int hw, input int hb,
                                         input int va, input int vf, input int vw, input int vb,
                                         input int pd, input logic pol);
      int ht, vt, k, n, p, x, y, px, py;
      logic pe, von, fs, hs, vs;
      logic [11:0] rgb;
      logic [2:0] bar;
      ht = ha + hf + hw + hb;
      vt = va + vf + vw + vb;
      pe = 1'b0; x = 0; y = 0; von = 1'b0; fs = 1'b0; hs = ~pol; vs = ~pol; rgb = 12'h000; bar = 3'd0;
      if (c > 0) begin
         k  = c / pd;
         n  = k % (ht * vt);
         x  = n % ht;
         y  = n / ht;
         pe = (c % pd == 0);
         if (k >= 1) begin
            von = (x < ha) && (y < va);
            fs  = pe && (n == 0);
         end
         if (k >= 2) begin
            p  = (k - 1) % (ht * vt);
            px = p % ht;
            py = p / ht;
            hs = (px >= ha + hf && px < ha + hf + hw) ? pol : ~pol;
            vs = (py >= va + vf && py < va + vf + vw) ? pol : ~pol;
            if (px < ha && py < va) begin
`ifdef VGA_COLOR_BARS_EN
               bar = 3'(px / (ha / 8));
               rgb = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
`else
               rgb = hist[(k * pd) & MASK];
`endif
            end
         end
      end
      return {pe, 10'(x), 10'(y), von, fs, hs, vs, rgb};
   endfunction

   function automatic logic [36:0] exp_a(input int c);
      return model(c, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0);
   endfunction

   function automatic logic [36:0] exp_b(input int c);
      return model(c, 16, 2, 4, 2, 6, 1, 2, 1, 3, 1'b1);
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      {r_in, g_in, b_in} = 12'h000;
      repeat (2) begin
         @(negedge clk);
         n_vec++;
         if (a_obs !== exp_a(0)) begin
            n_err++;
            $display("FAIL reset_a got=%h exp=%h", a_obs, exp_a(0));
         end
         n_vec++;
         if (b_obs !== exp_b(0)) begin
            n_err++;
            $display("FAIL reset_b got=%h exp=%h", b_obs, exp_b(0));
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_blanking_edge();
      logic [11:0] col639;
`ifdef VGA_COLOR_BARS_EN
      col639 = 12'hFFF;
`else
      col639 = 12'hAAA;
`endif
      {r_in, g_in, b_in} = 12'hAAA;
      for (int i = 0; i < 1400 && cyc < 1283; i++) begin
         @(negedge clk);
         n_vec++;
         if (a_obs !== exp_a(cyc)) begin
            n_err++;
            $display("FAIL edge_model c=%0d got=%h exp=%h", cyc, a_obs, exp_a(cyc));
         end
         if (cyc == 1 || cyc == 2) begin
            n_vec++;
            if (a_pix_en !== (cyc == 2)) begin
               n_err++;
               $display("FAIL first_pix_en c=%0d got=%b exp=%b", cyc, a_pix_en, cyc == 2);
            end
         end
         if (cyc == 1280) begin
            n_vec++;
            if ({a_pix_x, a_red, a_green, a_blue} !== {10'd640, col639}) begin
               n_err++;
               $display("FAIL edge_x639 got x=%0d rgb=%h exp x=640 rgb=%h", a_pix_x, {a_red, a_green, a_blue}, col639);
            end
         end
         if (cyc == 1282) begin
            n_vec++;
            if ({a_pix_x, a_red, a_green, a_blue} !== {10'd641, 12'h000}) begin
               n_err++;
               $display("FAIL edge_x640 got x=%0d rgb=%h exp x=641 rgb=000", a_pix_x, {a_red, a_green, a_blue});
            end
         end
      end
      n_vec++;
      if (cyc < 1283) begin
         n_err++;
         $display("FAIL edge_timeout got c=%0d exp c>=1283", cyc);
      end
   endtask

   task automatic test_line();
      int strobe = -1, fall = -1, rise = -1;
      logic prev_hs = a_hs;
      for (int i = 0; i < 4000 && cyc < 3200; i++) begin
         @(negedge clk);
         n_vec++;
         if (a_obs !== exp_a(cyc)) begin
            n_err++;
            $display("FAIL line_model c=%0d got=%h exp=%h", cyc, a_obs, exp_a(cyc));
         end
         if (strobe < 0 && a_pix_en && a_pix_x == 10'd0) strobe = cyc;
         if (strobe >= 0 && fall < 0 && prev_hs && !a_hs) fall = cyc;
         if (fall >= 0 && rise < 0 && !prev_hs && a_hs) rise = cyc;
         prev_hs = a_hs;
         {r_in, g_in, b_in} = 12'($urandom);
      end
      n_vec++;
      if (fall - strobe !== 1314 || strobe < 0) begin
         n_err++;
         $display("FAIL hsync_start got=%0d exp=1314 (strobe c=%0d)", fall - strobe, strobe);
      end
      n_vec++;
      if (rise - fall !== 192 || fall < 0) begin
         n_err++;
         $display("FAIL hsync_width got=%0d exp=192", rise - fall);
      end
   endtask

   task automatic test_frame();
      int fs1 = -1, fs2 = -1, vrise = -1, vfall = -1;
      logic prev_vs = b_vs;
      for (int i = 0; i < 1600; i++) begin
         @(negedge clk);
         n_vec++;
         if (b_obs !== exp_b(cyc)) begin
            n_err++;
            $display("FAIL frame_model c=%0d got=%h exp=%h", cyc, b_obs, exp_b(cyc));
         end
         if (b_frame_start) begin
            if (fs1 < 0) fs1 = cyc;
            else if (fs2 < 0) fs2 = cyc;
         end
         if (vrise < 0 && !prev_vs && b_vs) vrise = cyc;
         if (vrise >= 0 && vfall < 0 && prev_vs && !b_vs) vfall = cyc;
         prev_vs = b_vs;
         {r_in, g_in, b_in} = 12'($urandom);
      end
      n_vec++;
      if (fs2 - fs1 !== 720 || fs1 < 0) begin
         n_err++;
         $display("FAIL frame_period got=%0d exp=720", fs2 - fs1);
      end
      n_vec++;
      if (vfall - vrise !== 144 || vrise < 0) begin
         n_err++;
         $display("FAIL vsync_width got=%0d exp=144", vfall - vrise);
      end
   endtask

   task automatic test_reset_midframe();
      int first_hs = -1;
      for (int i = 0; i < 2000 && a_pix_x != 10'd700; i++) @(negedge clk);
      n_vec++;
      if (a_pix_x !== 10'd700) begin
         n_err++;
         $display("FAIL mid_wait got x=%0d exp x=700", a_pix_x);
      end
      #5 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({a_obs, b_obs} !== {exp_a(0), exp_b(0)}) begin
         n_err++;
         $display("FAIL mid_async got=%h/%h exp=%h/%h", a_obs, b_obs, exp_a(0), exp_b(0));
      end
      repeat (3) begin
         @(negedge clk);
         n_vec++;
         if ({a_obs, b_obs} !== {exp_a(0), exp_b(0)}) begin
            n_err++;
            $display("FAIL mid_hold got=%h/%h exp=%h/%h", a_obs, b_obs, exp_a(0), exp_b(0));
         end
      end
      rst_n = 1'b1;
      for (int i = 0; i < 1400; i++) begin
         @(negedge clk);
         n_vec++;
         if (a_obs !== exp_a(cyc)) begin
            n_err++;
            $display("FAIL mid_model_a c=%0d got=%h exp=%h", cyc, a_obs, exp_a(cyc));
         end
         n_vec++;
         if (b_obs !== exp_b(cyc)) begin
            n_err++;
            $display("FAIL mid_model_b c=%0d got=%h exp=%h", cyc, b_obs, exp_b(cyc));
         end
         if (first_hs < 0 && !a_hs) first_hs = cyc;
         {r_in, g_in, b_in} = 12'($urandom);
      end
      n_vec++;
      if (first_hs !== 1314) begin
         n_err++;
         $display("FAIL mid_first_hsync got c=%0d exp c=1314", first_hs);
      end
   endtask

   initial begin
      test_reset();
      test_blanking_edge();
      test_line();
      test_frame();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
